cpcs_tx_framer: RTL and testbench

CPCS_TX_FRAMER -- requirements
Module: cpcs_tx_framer

---
 rtl/cpcs_pkg.sv | 19 +
 rtl/cpcs_tx_framer.sv | 99 +++++++++
 tb/tb_cpcs_tx_framer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpcs_pkg.sv
// rtl/cpcs_pkg.sv - shared 8b/10b ordered-set characters and framer state type
package cpcs_pkg;

  // Special characters presented to the 8b/10b encoder (K flag carried separately)
  localparam logic [7:0] K28_5 = 8'hBC;  // idle comma, even slots
  localparam logic [7:0] D16_2 = 8'h50;  // idle filler, odd slots
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/ error propagation

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOF,
    ST_EXT
  } framer_state_t;

endpackage

// File: rtl/cpcs_tx_framer.sv
// rtl/cpcs_tx_framer.sv - wraps payload beats into /S/ ... /T/R/ frames with idle fill
module cpcs_tx_framer
  import cpcs_pkg::*;
#(
  parameter int MIN_IPG = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] d,
  output logic       k,
  output logic       force_disp,
  output logic       disp_sel,
  output logic       busy,
  output logic       underrun
);

  localparam logic [7:0] IPG = 8'(MIN_IPG);

  framer_state_t state;
  logic          slot_odd;    // parity of the character being produced this cycle
  logic [7:0]    idle_cnt;    // idle characters since the last frame, saturating
  logic          first_char;  // the next character is the first one after reset

  // Framer FSM: one output character per clock, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      d          <= K28_5;
      k          <= 1'b1;
      slot_odd   <= 1'b1;
      idle_cnt   <= IPG;
      first_char <= 1'b1;
      force_disp <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      slot_odd   <= ~slot_odd;
      force_disp <= first_char;
      first_char <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // /S/ only replaces a K28.5, so the frame always starts on an even slot
          if (!slot_odd && tx_valid && idle_cnt == IPG) begin
            d        <= K27_7;
            k        <= 1'b1;
            idle_cnt <= '0;
            state    <= ST_DATA;
          end else begin
            d <= slot_odd ? D16_2 : K28_5;
            k <= ~slot_odd;
            if (idle_cnt != IPG) begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        ST_DATA: begin
          if (tx_valid) begin
            d <= tx_data;
            k <= 1'b0;
            if (tx_last) begin
              state <= ST_EOF;
            end
          end else begin
            // Source starved mid-frame: poison the frame and close it
            d        <= K30_7;
            k        <= 1'b1;
            underrun <= 1'b1;
            state    <= ST_EOF;
          end
        end
        ST_EOF: begin
          d     <= K29_7;
          k     <= 1'b1;
          state <= ST_EXT;
        end
        ST_EXT: begin
          // Leave once this /R/ is odd, so idle resumes on an even slot
          d <= K23_7;
          k <= 1'b1;
          if (slot_odd) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (state == ST_DATA);
  assign busy     = (state != ST_IDLE);
  assign disp_sel = 1'b0;

endmodule

// File: tb/tb_cpcs_tx_framer.sv
// tb/tb_cpcs_tx_framer.sv - directed self-checking bench for cpcs_tx_framer
module tb_cpcs_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] d;
  logic       k;
  logic       force_disp;
  logic       disp_sel;
  logic       busy;
  logic       underrun;

  int n_vec = 0;
  int n_bad = 0;

  cpcs_tx_framer #(.MIN_IPG(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .d          (d),
    .k          (k),
    .force_disp (force_disp),
    .disp_sel   (disp_sel),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [8:0] e);
    step();
    chk(tag, {23'd0, k, d}, {23'd0, e});
  endtask

  task automatic wait_sof(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(k && d == 8'hFB) && n < 64);
    chk("sof_seen", {31'd0, (k && d == 8'hFB)}, 32'd1);
  endtask

  logic [7:0] b3   [3] = '{8'h11, 8'h22, 8'h33};
  logic [8:0] exp3 [7] = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1F7, 9'h1BC};

  initial begin
    int  idx;
    int  rdy;
    int  n;
    logic acc;

    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    repeat (3) step();
    chk("rst_char", {23'd0, k, d}, 32'h1BC);
    chk("rst_force", {31'd0, force_disp}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, tx_ready}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_disp_sel", {31'd0, disp_sel}, 0);

    // Idle pattern after release, FORCE_DISP on the first character only
    rst = 1'b0;
    step_chk("idle0", 9'h050);
    chk("idle0_force", {31'd0, force_disp}, 1);
    chk("idle0_disp_sel", {31'd0, disp_sel}, 0);
    step_chk("idle1", 9'h1BC);
    chk("idle1_force", {31'd0, force_disp}, 0);
    step_chk("idle2", 9'h050);
    step_chk("idle3", 9'h1BC);

    // Valid raised before an odd slot: /S/ waits one character
    tx_valid = 1'b1; tx_data = b3[0]; tx_last = 1'b0;
    step_chk("odd_hold", 9'h050);
    chk("odd_hold_ready", {31'd0, tx_ready}, 0);

    // Three-byte frame with valid held high
    idx = 0; rdy = 0;
    for (int c = 0; c < 7; c++) begin
      acc = tx_ready && tx_valid;
      if (tx_ready) rdy++;
      step();
      chk($sformatf("frame3_c%0d", c), {23'd0, k, d}, {23'd0, exp3[c]});
      if (acc) begin
        idx++;
        if (idx < 3) begin
          tx_data = b3[idx];
          tx_last = (idx == 2);
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
    end
    chk("frame3_ready_cycles", rdy, 3);
    chk("frame3_idle_busy", {31'd0, busy}, 0);

    // Valid raised four idles after a frame: /S/ waits for twelve idles
    step_chk("gap2", 9'h050);
    step_chk("gap3", 9'h1BC);
    step_chk("gap4", 9'h050);
    tx_valid = 1'b1; tx_data = 8'hAA; tx_last = 1'b1;
    for (int i = 5; i <= 12; i++) begin
      step_chk($sformatf("gap%0d", i), (i % 2) ? 9'h1BC : 9'h050);
      chk($sformatf("gap%0d_ready", i), {31'd0, tx_ready}, 0);
    end
    step_chk("sof_aa", 9'h1FB);
    chk("aa_ready", {31'd0, tx_ready}, 1);
    step_chk("byte_aa", 9'h0AA);
    tx_data = 8'hBB;
    step_chk("eof_aa", 9'h1FD);
    chk("eof_aa_ready", {31'd0, tx_ready}, 0);
    step_chk("ext_aa", 9'h1F7);

    // Back-to-back frame: exactly twelve idles between /R/ and /S/
    for (int i = 1; i <= 12; i++) begin
      step_chk($sformatf("b2b_idle%0d", i), (i % 2) ? 9'h1BC : 9'h050);
    end
    step_chk("sof_bb", 9'h1FB);
    chk("bb_ready", {31'd0, tx_ready}, 1);
    step_chk("byte_bb", 9'h0BB);
    tx_valid = 1'b0; tx_last = 1'b0;
    step_chk("eof_bb", 9'h1FD);
    step_chk("ext_bb", 9'h1F7);
    step_chk("idle_bb", 9'h1BC);

    // Underrun: source stops after two bytes
    tx_valid = 1'b1; tx_data = 8'h01; tx_last = 1'b0;
    wait_sof(n);
    chk("ur_sof_wait", n, 12);
    chk("ur_ready", {31'd0, tx_ready}, 1);
    step_chk("ur_b1", 9'h001);
    tx_data = 8'h02;
    step_chk("ur_b2", 9'h002);
    chk("ur_b2_pulse", {31'd0, underrun}, 0);
    tx_valid = 1'b0;
    step_chk("ur_fe", 9'h1FE);
    chk("ur_pulse", {31'd0, underrun}, 1);
    step_chk("ur_fd", 9'h1FD);
    chk("ur_pulse_end", {31'd0, underrun}, 0);
    step_chk("ur_ext", 9'h1F7);
    step_chk("ur_idle", 9'h1BC);

    // Two-byte frame: /T/ lands odd, so /R/ is doubled
    tx_valid = 1'b1; tx_data = 8'hA1; tx_last = 1'b0;
    wait_sof(n);
    chk("f2_sof_wait", n, 12);
    step_chk("f2_b1", 9'h0A1);
    tx_data = 8'hA2; tx_last = 1'b1;
    step_chk("f2_b2", 9'h0A2);
    tx_valid = 1'b0; tx_last = 1'b0;
    step_chk("f2_eof", 9'h1FD);
    step_chk("f2_ext1", 9'h1F7);
    chk("f2_ext1_busy", {31'd0, busy}, 1);
    step_chk("f2_ext2", 9'h1F7);
    chk("f2_ext2_busy", {31'd0, busy}, 0);
    step_chk("f2_idle", 9'h1BC);

    // Reset during the third byte abandons the frame
    tx_valid = 1'b1; tx_data = 8'h31; tx_last = 1'b0;
    wait_sof(n);
    step_chk("rf_b1", 9'h031);
    tx_data = 8'h32;
    step_chk("rf_b2", 9'h032);
    tx_data = 8'h33;
    rst = 1'b1;
    step_chk("rf_rst_char", 9'h1BC);
    chk("rf_rst_busy", {31'd0, busy}, 0);
    chk("rf_rst_ready", {31'd0, tx_ready}, 0);
    chk("rf_rst_force", {31'd0, force_disp}, 0);
    rst = 1'b0; tx_valid = 1'b0;
    step_chk("rf_idle0", 9'h050);
    chk("rf_idle0_force", {31'd0, force_disp}, 1);
    step_chk("rf_idle1", 9'h1BC);
    chk("rf_idle1_force", {31'd0, force_disp}, 0);
    step_chk("rf_idle2", 9'h050);
    step_chk("rf_idle3", 9'h1BC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
